// File: rtl/shifter_pkg.sv
// Shared definitions for the multi-cycle shift sequencer: state encoding,
// shift directions and default geometry.
package shifter_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_AMT_W = 5;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // 2'd3 is unused; the sequencer decodes it as IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_stage_1.sv
// Combinational single-position shifter: arithmetic right or logical left.
module shift_stage_1
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             dir,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_comb begin
        if (dir == DIR_RIGHT) begin
            q = {d[WIDTH-1], d[WIDTH-1:1]};
        end else begin
            q = {d[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: reuses one single-position stage SH_AMT times
// per request, with valid/ready handshakes on both the request and result sides.
module shift_sequencer
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned AMT_W = DEF_AMT_W,
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic             SH_DIR,
    input  logic [AMT_W-1:0] SH_AMT,
    input  logic [WIDTH-1:0] D_IN,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [WIDTH-1:0] D_OUT,
    output logic             BUSY,
    output logic [CNT_W-1:0] OPS_DONE
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic [CNT_W-1:0]   ops_q, ops_d;
    logic [WIDTH-1:0]   stage_q;
    logic               req_ready;
    logic               busy;
    logic               load;

    shift_stage_1 #(
        .WIDTH(WIDTH)
    ) u_stage (
        .dir(dir_q),
        .d  (data_q),
        .q  (stage_q)
    );

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        ops_d     = ops_q;
        req_ready = 1'b0;
        busy      = 1'b0;
        load      = 1'b0;

        case (state_q)
            ST_SHIFT: begin
                busy   = 1'b1;
                data_d = stage_q;
                cnt_d  = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                req_ready = RES_READY;
                if (RES_READY) begin
                    ops_d   = ops_q + CNT_W'(1);
                    state_d = ST_IDLE;
                    load    = REQ_VALID;
                end
            end
            default: begin
                req_ready = 1'b1;
                load      = REQ_VALID;
            end
        endcase

        // Request capture is shared by IDLE and the back-to-back path out of DONE.
        if (load) begin
            dir_d   = SH_DIR;
            cnt_d   = SH_AMT;
            data_d  = D_IN;
            state_d = (SH_AMT == '0) ? ST_DONE : ST_SHIFT;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= DIR_LEFT;
            ops_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            ops_q   <= ops_d;
        end
    end

    assign REQ_READY = req_ready && !RST;
    assign BUSY      = busy && !RST;
    assign RES_VALID = (state_q == ST_DONE);
    assign D_OUT     = data_q;
    assign OPS_DONE  = ops_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: vector table plus hand-written
// sequences, with results tracked through an expected-result queue.
module tb_shift_sequencer;

    localparam int unsigned W   = 32;
    localparam int unsigned AW  = 5;
    localparam int unsigned CW  = 4;

    logic          clk = 1'b0;
    logic          RST, REQ_VALID, REQ_READY, SH_DIR, RES_VALID, RES_READY, BUSY;
    logic [AW-1:0] SH_AMT;
    logic [W-1:0]  D_IN, D_OUT;
    logic [CW-1:0] OPS_DONE;

    shift_sequencer #(
        .WIDTH(W),
        .AMT_W(AW),
        .CNT_W(CW)
    ) dut (
        .CLK      (clk),
        .RST      (RST),
        .REQ_VALID(REQ_VALID),
        .REQ_READY(REQ_READY),
        .SH_DIR   (SH_DIR),
        .SH_AMT   (SH_AMT),
        .D_IN     (D_IN),
        .RES_VALID(RES_VALID),
        .RES_READY(RES_READY),
        .D_OUT    (D_OUT),
        .BUSY     (BUSY),
        .OPS_DONE (OPS_DONE)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          dir;
        logic [AW-1:0] amt;
        logic [W-1:0]  din;
        logic [W-1:0]  exp;
    } vec_t;

    typedef struct {
        logic [W-1:0] exp;
        int unsigned  amt;
        int unsigned  hs;
    } sb_t;

    sb_t           sbq[$];
    vec_t          vecs[10];
    int unsigned   cyc = 0;
    int unsigned   n_cmp = 0;
    int unsigned   n_fail = 0;
    logic [CW-1:0] exp_ops = '0;
    bit            head_seen = 0;
    bit            prev_rv = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] model(input logic dir, input logic [AW-1:0] amt,
                                           input logic [W-1:0] din);
        logic [W-1:0] r = din;
        for (int i = 0; i < int'(amt); i++) begin
            r = dir ? {r[W-1], r[W-1:1]} : {r[W-2:0], 1'b0};
        end
        return r;
    endfunction

    // Result monitor: latency on first sight of a result, data and count on handshake.
    always @(negedge clk) begin
        if (!RST) begin
            if (RES_VALID) begin
                if (sbq.size() == 0) begin
                    if (!prev_rv) check("unexpected_result", 32'(RES_VALID), 32'd0);
                end else begin
                    if (!head_seen) begin
                        check("latency", cyc - sbq[0].hs, sbq[0].amt + 1);
                        head_seen = 1;
                    end
                    if (RES_READY) begin
                        check("d_out", D_OUT, sbq[0].exp);
                        check("ops_done", 32'(OPS_DONE), 32'(exp_ops));
                        exp_ops = exp_ops + 1'b1;
                        void'(sbq.pop_front());
                        head_seen = 0;
                    end
                end
            end
            prev_rv = RES_VALID;
        end
    end

    // Tasks start and end 1 time unit after a rising edge.
    task automatic send(input logic dir, input logic [AW-1:0] amt, input logic [W-1:0] din,
                        input logic [W-1:0] exp);
        int unsigned waited = 0;
        REQ_VALID = 1'b1;
        SH_DIR    = dir;
        SH_AMT    = amt;
        D_IN      = din;
        forever begin
            @(negedge clk);
            if (REQ_READY) break;
            waited++;
            if (waited > 100) begin
                check("req_ready_timeout", 32'(REQ_READY), 32'd1);
                break;
            end
        end
        if (REQ_READY) sbq.push_back('{exp: exp, amt: int'(amt), hs: cyc});
        @(posedge clk); #1;
        REQ_VALID = 1'b0;
    endtask

    task automatic wait_drain(input int unsigned budget);
        int unsigned k = 0;
        while (sbq.size() != 0 && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check("drain", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd4,  32'hF000_0010, 32'hFF00_0001};
        vecs[1] = '{1'b0, 5'd0,  32'h1234_5678, 32'h1234_5678};
        vecs[2] = '{1'b0, 5'd31, 32'h0000_0003, 32'h8000_0000};
        vecs[3] = '{1'b1, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF};
        vecs[4] = '{1'b0, 5'd1,  32'h8000_0001, 32'h0000_0002};
        vecs[5] = '{1'b1, 5'd1,  32'h7FFF_FFFE, 32'h3FFF_FFFF};
        vecs[6] = '{1'b0, 5'd8,  32'h0000_00AB, 32'h0000_AB00};
        vecs[7] = '{1'b1, 5'd16, 32'h8000_1234, 32'hFFFF_8000};
        vecs[8] = '{1'b1, 5'd3,  32'h0000_0080, 32'h0000_0010};
        vecs[9] = '{1'b0, 5'd4,  32'h1234_5678, 32'h2345_6780};

        RST = 1'b1; REQ_VALID = 1'b0; SH_DIR = 1'b0; SH_AMT = '0; D_IN = '0; RES_READY = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_req_ready", 32'(REQ_READY), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        @(posedge clk); #1;
        RST = 1'b0;
        @(negedge clk);
        check("idle_req_ready", 32'(REQ_READY), 32'd1);
        check("idle_res_valid", 32'(RES_VALID), 32'd0);
        check("idle_ops_done", 32'(OPS_DONE), 32'd0);
        check("idle_d_out", D_OUT, 32'd0);
        check("idle_busy", 32'(BUSY), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            send(vecs[i].dir, vecs[i].amt, vecs[i].din, vecs[i].exp);
            wait_drain(64);
        end

        // Backpressure, then release with a new request in the same cycle.
        RES_READY = 1'b0;
        send(1'b1, 5'd3, 32'h0000_0080, 32'h0000_0010);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (RES_VALID) break;
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_d_out", D_OUT, 32'h0000_0010);
            check("bp_res_valid", 32'(RES_VALID), 32'd1);
            check("bp_req_ready", 32'(REQ_READY), 32'd0);
            check("bp_ops_done", 32'(OPS_DONE), 32'(exp_ops));
        end
        @(posedge clk); #1;
        RES_READY = 1'b1;
        send(1'b0, 5'd2, 32'h0000_0005, 32'h0000_0014);
        wait_drain(64);

        // Inputs changed while the operation is in flight must be ignored.
        send(1'b1, 5'd6, 32'h8000_00F0, 32'hFE00_0003);
        D_IN = '1; SH_AMT = 5'd1; SH_DIR = 1'b0;
        wait_drain(64);

        // Extra operations push the narrow op counter through its wrap.
        for (int i = 0; i < 8; i++) begin
            logic          d = 1'($urandom_range(0, 1));
            logic [AW-1:0] a = AW'($urandom_range(0, 3));
            logic [W-1:0]  x = $urandom;
            send(d, a, x, model(d, a, x));
            wait_drain(64);
        end

        // Reset mid-operation drops the result.
        send(1'b0, 5'd20, 32'h0000_0001, 32'h0010_0000);
        repeat (5) @(posedge clk);
        #1;
        RST = 1'b1;
        sbq.delete();
        head_seen = 0;
        exp_ops = '0;
        @(negedge clk);
        check("mid_rst_req_ready", 32'(REQ_READY), 32'd0);
        check("mid_rst_busy", 32'(BUSY), 32'd0);
        @(posedge clk); #1;
        RST = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 32'(BUSY), 32'd0);
        check("post_rst_res_valid", 32'(RES_VALID), 32'd0);
        check("post_rst_ops_done", 32'(OPS_DONE), 32'd0);
        check("post_rst_d_out", D_OUT, 32'd0);
        check("post_rst_req_ready", 32'(REQ_READY), 32'd1);
        @(posedge clk); #1;
        repeat (30) @(posedge clk);
        #1;

        // Request coinciding with reset is not accepted.
        RST = 1'b1; REQ_VALID = 1'b1; SH_AMT = '0; D_IN = 32'hDEAD_BEEF;
        @(negedge clk);
        check("rst_req_same_cycle_ready", 32'(REQ_READY), 32'd0);
        @(posedge clk); #1;
        RST = 1'b0; REQ_VALID = 1'b0;
        @(negedge clk);
        check("rst_req_busy", 32'(BUSY), 32'd0);
        check("rst_req_res_valid", 32'(RES_VALID), 32'd0);
        @(posedge clk); #1;

        send(1'b1, 5'd2, 32'hC000_0000, 32'hF000_0000);
        wait_drain(64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
